// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle control FSM: state encoding,
// instruction classes, immediate selectors, opcode constants and the
// byte-enable helper used by both memory access states.
package mc_ctrl_pkg;

   // Controller states; the numeric values double as the debug state output
   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      LD_WB    = 4'd4,
      MEM_WR   = 4'd5,
      R_EX     = 4'd6,
      ALU_WB   = 4'd7,
      BR       = 4'd8,
      JAL_EX   = 4'd9,
      JALR_EX  = 4'd10,
      LINK_WB  = 4'd11,
      I_EX     = 4'd12,
      U_EX     = 4'd13,
      U_WB     = 4'd14,
      TRAP     = 4'd15
   } ctrlState_t;

   // Instruction classes produced by the decoder
   typedef enum logic [3:0] {
      CLS_LOAD    = 4'd0,
      CLS_STORE   = 4'd1,
      CLS_REG     = 4'd2,
      CLS_BRANCH  = 4'd3,
      CLS_JAL     = 4'd4,
      CLS_JALR    = 4'd5,
      CLS_IMM     = 4'd6,
      CLS_UPPER   = 4'd7,
      CLS_ILLEGAL = 4'd8
   } instrClass_t;

   // Immediate generator selectors
   localparam logic [2:0] IMM_NONE  = 3'b000;
   localparam logic [2:0] IMM_U     = 3'b001;
   localparam logic [2:0] IMM_J     = 3'b010;
   localparam logic [2:0] IMM_I     = 3'b011;
   localparam logic [2:0] IMM_B     = 3'b100;
   localparam logic [2:0] IMM_S     = 3'b101;
   localparam logic [2:0] IMM_SHAMT = 3'b110;

   // Major opcodes
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   // Byte lanes touched by a load/store of the given width code
   function automatic logic [3:0] byteEnables(input logic [2:0] funct3);
      logic [3:0] lanes;
      case (funct3)
         3'b000, 3'b100: lanes = 4'b0001;
         3'b001, 3'b101: lanes = 4'b0011;
         3'b010:         lanes = 4'b1111;
         default:        lanes = 4'b0000;
      endcase
      return lanes;
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier. Anything the datapath cannot
// execute, including unsupported load/store widths, is reported as illegal.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   output instrClass_t instrClass
);

   // Map opcode (and width field for memory ops) onto an instruction class;
   // unknown opcodes fall through to the illegal class
   always_comb begin
      instrClass = CLS_ILLEGAL;
      case (opcode)
         OP_LOAD: begin
            if (funct3 inside {3'b011, 3'b110, 3'b111})
               instrClass = CLS_ILLEGAL;
            else
               instrClass = CLS_LOAD;
         end
         OP_STORE: begin
            if (funct3 > 3'b010)
               instrClass = CLS_ILLEGAL;
            else
               instrClass = CLS_STORE;
         end
         OP_REG:   instrClass = CLS_REG;
         OP_BR:    instrClass = CLS_BRANCH;
         OP_JAL:   instrClass = CLS_JAL;
         OP_JALR:  instrClass = CLS_JALR;
         OP_IMM:   instrClass = CLS_IMM;
         OP_LUI,
         OP_AUIPC: instrClass = CLS_UPPER;
         default:  instrClass = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle processor control unit: sequences fetch, decode, execute,
// memory and write-back states and counts retired instructions.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_HS  = 1,
   parameter int TRAP_EN = 1,
   parameter int CNT_W   = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             pc_write,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             alu_src1,
   output logic             alu_src2,
   output logic             branch,
   output logic             jump,
   output logic             jal_or_jalr,
   output logic             trap,
   output logic [6:0]       alu_op,
   output logic [2:0]       imm_sel,
   output logic [3:0]       be,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instret
);

   ctrlState_t  stateReg;
   ctrlState_t  nextState;
   instrClass_t instrClass;
   logic        memReadyEff;
   logic        retire;

   mc_ctrl_decode uDecode (
      .opcode     (opcode),
      .funct3     (funct3),
      .instrClass (instrClass)
   );

   // Without the handshake every access completes at once; reset masks
   // completion so the outputs during reset look like a stalled fetch
   assign memReadyEff = ((MEM_HS != 0) ? mem_ready : 1'b1) & ~RST;

   // An instruction retires when it returns to FETCH from any execute path;
   // FETCH holding and the silent illegal-drop from DECODE do not count
   assign retire = (nextState == FETCH) && (stateReg != FETCH) && (stateReg != DECODE);

   assign alu_op = opcode;
   assign state  = stateReg;

   // State register; reset aborts whatever instruction is in flight
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         stateReg <= FETCH;
      else
         stateReg <= nextState;
   end

   // Retired-instruction counter, wrapping naturally at its width
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         instret <= '0;
      else if (retire)
         instret <= instret + CNT_W'(1);
   end

   // Next-state logic: memory states wait for completion, TRAP is absorbing,
   // everything else walks its fixed path back to FETCH
   always_comb begin
      nextState = stateReg;
      case (stateReg)
         FETCH:    if (memReadyEff) nextState = DECODE;
         DECODE: begin
            case (instrClass)
               CLS_LOAD,
               CLS_STORE:  nextState = MEM_ADDR;
               CLS_REG:    nextState = R_EX;
               CLS_BRANCH: nextState = BR;
               CLS_JAL:    nextState = JAL_EX;
               CLS_JALR:   nextState = JALR_EX;
               CLS_IMM:    nextState = I_EX;
               CLS_UPPER:  nextState = U_EX;
               default:    nextState = (TRAP_EN != 0) ? TRAP : FETCH;
            endcase
         end
         MEM_ADDR: nextState = (instrClass == CLS_STORE) ? MEM_WR : MEM_RD;
         MEM_RD:   if (memReadyEff) nextState = LD_WB;
         MEM_WR:   if (memReadyEff) nextState = FETCH;
         LD_WB:    nextState = FETCH;
         R_EX:     nextState = ALU_WB;
         ALU_WB:   nextState = FETCH;
         BR:       nextState = FETCH;
         JAL_EX:   nextState = LINK_WB;
         JALR_EX:  nextState = LINK_WB;
         LINK_WB:  nextState = FETCH;
         I_EX:     nextState = ALU_WB;
         U_EX:     nextState = U_WB;
         U_WB:     nextState = FETCH;
         TRAP:     nextState = TRAP;
         default:  nextState = FETCH;
      endcase
   end

   // Moore-style control decode: every output starts inactive and only the
   // current state turns on what it needs
   always_comb begin
      mem_req     = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      mem_to_reg  = 1'b0;
      alu_src1    = 1'b0;
      alu_src2    = 1'b0;
      branch      = 1'b0;
      jump        = 1'b0;
      jal_or_jalr = 1'b0;
      trap        = 1'b0;
      imm_sel     = IMM_NONE;
      be          = 4'b0000;
      case (stateReg)
         FETCH: begin
            mem_req  = 1'b1;
            mem_read = 1'b1;
            ir_write = memReadyEff;
            pc_write = memReadyEff;
         end
         MEM_ADDR: begin
            alu_src2 = 1'b1;
            imm_sel  = (instrClass == CLS_STORE) ? IMM_S : IMM_I;
         end
         MEM_RD: begin
            mem_req  = 1'b1;
            mem_read = 1'b1;
            be       = byteEnables(funct3);
         end
         MEM_WR: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            be        = byteEnables(funct3);
         end
         LD_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         ALU_WB, LINK_WB, U_WB: reg_write = 1'b1;
         BR: begin
            branch  = 1'b1;
            imm_sel = IMM_B;
         end
         JAL_EX: begin
            alu_src1 = 1'b1;
            alu_src2 = 1'b1;
            jump     = 1'b1;
            imm_sel  = IMM_J;
            pc_write = 1'b1;
         end
         JALR_EX: begin
            alu_src2    = 1'b1;
            jump        = 1'b1;
            jal_or_jalr = 1'b1;
            imm_sel     = IMM_I;
            pc_write    = 1'b1;
         end
         I_EX: begin
            alu_src2 = 1'b1;
            imm_sel  = (funct3 inside {3'b001, 3'b101}) ? IMM_SHAMT : IMM_I;
         end
         U_EX: begin
            alu_src1 = 1'b1;
            alu_src2 = 1'b1;
            imm_sel  = IMM_U;
         end
         TRAP: trap = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: randomized legal instruction
// streams against a path/output reference model, plus directed illegal,
// trap, reset-abort and no-handshake scenarios on three parameterisations.
module tb_mc_control_fsm;

   typedef struct packed {
      logic       memReq;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic       pcWrite;
      logic       regWrite;
      logic       memToReg;
      logic       aluSrc1;
      logic       aluSrc2;
      logic       branch;
      logic       jump;
      logic       jalOrJalr;
      logic       trap;
      logic [2:0] immSel;
      logic [3:0] be;
   } ctrlOut_t;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_REG   = 7'b0110011;
   localparam logic [6:0] OPC_BR    = 7'b1100011;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;
   localparam logic [6:0] OPC_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [6:0]  opcode = '0;
   logic [2:0]  funct3 = '0;
   logic        memReady = 1'b0;

   logic [19:0] ctrlMain, ctrlNoTrap, ctrlNoHs;
   logic [6:0]  aluOpMain, aluOpNoTrap, aluOpNoHs;
   logic [3:0]  stateMain, stateNoTrap, stateNoHs;
   logic [31:0] instretMain;
   logic [3:0]  instretNoTrap;
   logic [7:0]  instretNoHs;

   int checks = 0;
   int errors = 0;
   int expCount = 0;
   int pathState[$];
   logic pathReady[$];

   // Free-running clock
   always #5 CLK = ~CLK;

   mc_control_fsm dut (
      .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .mem_ready(memReady),
      .mem_req(ctrlMain[19]), .mem_read(ctrlMain[18]), .mem_write(ctrlMain[17]),
      .ir_write(ctrlMain[16]), .pc_write(ctrlMain[15]), .reg_write(ctrlMain[14]),
      .mem_to_reg(ctrlMain[13]), .alu_src1(ctrlMain[12]), .alu_src2(ctrlMain[11]),
      .branch(ctrlMain[10]), .jump(ctrlMain[9]), .jal_or_jalr(ctrlMain[8]),
      .trap(ctrlMain[7]), .alu_op(aluOpMain), .imm_sel(ctrlMain[6:4]),
      .be(ctrlMain[3:0]), .state(stateMain), .instret(instretMain)
   );

   mc_control_fsm #(.MEM_HS(1), .TRAP_EN(0), .CNT_W(4)) dutNoTrap (
      .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .mem_ready(memReady),
      .mem_req(ctrlNoTrap[19]), .mem_read(ctrlNoTrap[18]), .mem_write(ctrlNoTrap[17]),
      .ir_write(ctrlNoTrap[16]), .pc_write(ctrlNoTrap[15]), .reg_write(ctrlNoTrap[14]),
      .mem_to_reg(ctrlNoTrap[13]), .alu_src1(ctrlNoTrap[12]), .alu_src2(ctrlNoTrap[11]),
      .branch(ctrlNoTrap[10]), .jump(ctrlNoTrap[9]), .jal_or_jalr(ctrlNoTrap[8]),
      .trap(ctrlNoTrap[7]), .alu_op(aluOpNoTrap), .imm_sel(ctrlNoTrap[6:4]),
      .be(ctrlNoTrap[3:0]), .state(stateNoTrap), .instret(instretNoTrap)
   );

   mc_control_fsm #(.MEM_HS(0), .TRAP_EN(1), .CNT_W(8)) dutNoHs (
      .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .mem_ready(memReady),
      .mem_req(ctrlNoHs[19]), .mem_read(ctrlNoHs[18]), .mem_write(ctrlNoHs[17]),
      .ir_write(ctrlNoHs[16]), .pc_write(ctrlNoHs[15]), .reg_write(ctrlNoHs[14]),
      .mem_to_reg(ctrlNoHs[13]), .alu_src1(ctrlNoHs[12]), .alu_src2(ctrlNoHs[11]),
      .branch(ctrlNoHs[10]), .jump(ctrlNoHs[9]), .jal_or_jalr(ctrlNoHs[8]),
      .trap(ctrlNoHs[7]), .alu_op(aluOpNoHs), .imm_sel(ctrlNoHs[6:4]),
      .be(ctrlNoHs[3:0]), .state(stateNoHs), .instret(instretNoHs)
   );

   // Instruction kind: 0 load, 1 store, 2 reg, 3 branch, 4 jal, 5 jalr,
   // 6 imm, 7 upper, -1 illegal
   function automatic int classify(input logic [6:0] op, input logic [2:0] f3);
      if (op == OPC_LOAD)  return (f3 == 3'd3 || f3 >= 3'd6) ? -1 : 0;
      if (op == OPC_STORE) return (f3 <= 3'd2) ? 1 : -1;
      if (op == OPC_REG)   return 2;
      if (op == OPC_BR)    return 3;
      if (op == OPC_JAL)   return 4;
      if (op == OPC_JALR)  return 5;
      if (op == OPC_IMM)   return 6;
      if (op == OPC_LUI || op == OPC_AUIPC) return 7;
      return -1;
   endfunction

   // Expected control outputs for a state number; be is derived from the
   // access size in bytes (1, 2 or 4) as a mask of that many low lanes
   function automatic ctrlOut_t expectOut(input int st, input logic [6:0] op,
                                          input logic [2:0] f3, input logic rdy);
      ctrlOut_t e;
      int bytes;
      e = '0;
      bytes = 1 << f3[1:0];
      case (st)
         0:  begin e.memReq = 1'b1; e.memRead = 1'b1; e.irWrite = rdy; e.pcWrite = rdy; end
         2:  begin e.aluSrc2 = 1'b1; e.immSel = (op == OPC_STORE) ? 3'd5 : 3'd3; end
         3:  begin e.memReq = 1'b1; e.memRead = 1'b1; e.be = 4'((1 << bytes) - 1); end
         4:  begin e.regWrite = 1'b1; e.memToReg = 1'b1; end
         5:  begin e.memReq = 1'b1; e.memWrite = 1'b1; e.be = 4'((1 << bytes) - 1); end
         7, 11, 14: e.regWrite = 1'b1;
         8:  begin e.branch = 1'b1; e.immSel = 3'd4; end
         9:  begin e.aluSrc1 = 1'b1; e.aluSrc2 = 1'b1; e.jump = 1'b1; e.immSel = 3'd2; e.pcWrite = 1'b1; end
         10: begin e.aluSrc2 = 1'b1; e.jump = 1'b1; e.jalOrJalr = 1'b1; e.immSel = 3'd3; e.pcWrite = 1'b1; end
         12: begin e.aluSrc2 = 1'b1; e.immSel = (f3 == 3'd1 || f3 == 3'd5) ? 3'd6 : 3'd3; end
         13: begin e.aluSrc1 = 1'b1; e.aluSrc2 = 1'b1; e.immSel = 3'd1; end
         15: e.trap = 1'b1;
         default: ;
      endcase
      return e;
   endfunction

   function automatic logic randBit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic rdy);
      opcode   = op;
      funct3   = f3;
      memReady = rdy;
   endtask

   task automatic pushStep(input int st, input logic rdy);
      pathState.push_back(st);
      pathReady.push_back(rdy);
   endtask

   // Expected per-cycle state walk of one legal instruction, with the
   // mem_ready value to drive in each cycle
   task automatic buildPath(input logic [6:0] op, input logic [2:0] f3,
                            input int fetchStalls, input int memStalls);
      pathState.delete();
      pathReady.delete();
      repeat (fetchStalls) pushStep(0, 1'b0);
      pushStep(0, 1'b1);
      pushStep(1, randBit());
      case (classify(op, f3))
         0: begin
            pushStep(2, randBit());
            repeat (memStalls) pushStep(3, 1'b0);
            pushStep(3, 1'b1);
            pushStep(4, randBit());
         end
         1: begin
            pushStep(2, randBit());
            repeat (memStalls) pushStep(5, 1'b0);
            pushStep(5, 1'b1);
         end
         2: begin pushStep(6, randBit()); pushStep(7, randBit()); end
         3: pushStep(8, randBit());
         4: begin pushStep(9, randBit()); pushStep(11, randBit()); end
         5: begin pushStep(10, randBit()); pushStep(11, randBit()); end
         6: begin pushStep(12, randBit()); pushStep(7, randBit()); end
         7: begin pushStep(13, randBit()); pushStep(14, randBit()); end
         default: ;
      endcase
   endtask

   // Drive one legal instruction through both handshaking instances and
   // compare state, outputs and counters every cycle
   task automatic runInstruction(input logic [6:0] op, input logic [2:0] f3,
                                 input int fetchStalls, input int memStalls);
      ctrlOut_t exp;
      buildPath(op, f3, fetchStalls, memStalls);
      for (int i = 0; i < pathState.size(); i++) begin
         applyStimulus(op, f3, pathReady[i]);
         @(negedge CLK);
         exp = expectOut(pathState[i], op, f3, pathReady[i]);
         checks++;
         if (stateMain !== 4'(pathState[i])) begin
            errors++;
            $display("[TB] FAIL state op=%b f3=%b step %0d: got %0d expected %0d", op, f3, i, stateMain, pathState[i]);
         end
         checks++;
         if (stateNoTrap !== 4'(pathState[i])) begin
            errors++;
            $display("[TB] FAIL stateNoTrap op=%b step %0d: got %0d expected %0d", op, i, stateNoTrap, pathState[i]);
         end
         checks++;
         if (ctrlMain !== exp) begin
            errors++;
            $display("[TB] FAIL outputs op=%b f3=%b state %0d: got %h expected %h", op, f3, pathState[i], ctrlMain, exp);
         end
         checks++;
         if (ctrlNoTrap !== exp) begin
            errors++;
            $display("[TB] FAIL outputsNoTrap op=%b state %0d: got %h expected %h", op, pathState[i], ctrlNoTrap, exp);
         end
         checks++;
         if (aluOpMain !== op || aluOpNoTrap !== op) begin
            errors++;
            $display("[TB] FAIL alu_op: got %b/%b expected %b", aluOpMain, aluOpNoTrap, op);
         end
         checks++;
         if (instretMain !== 32'(expCount)) begin
            errors++;
            $display("[TB] FAIL instret: got %0d expected %0d", instretMain, expCount);
         end
         checks++;
         if (instretNoTrap !== 4'(expCount % 16)) begin
            errors++;
            $display("[TB] FAIL instret4: got %0d expected %0d", instretNoTrap, expCount % 16);
         end
         @(posedge CLK);
         #1;
      end
      expCount++;
   endtask

   task automatic doReset();
      RST = 1'b1;
      applyStimulus(OPC_REG, 3'd0, 1'b0);
      repeat (2) begin
         @(posedge CLK);
         #1;
      end
      RST = 1'b0;
      expCount = 0;
   endtask

   task automatic test_reset();
      logic [6:0] op;
      logic [2:0] f3;
      op = 7'($urandom);
      f3 = 3'($urandom);
      RST = 1'b1;
      applyStimulus(op, f3, 1'b1);
      @(posedge CLK);
      #1;
      @(negedge CLK);
      checks++;
      if (stateMain !== 4'd0 || stateNoTrap !== 4'd0 || stateNoHs !== 4'd0) begin
         errors++;
         $display("[TB] FAIL reset state: got %0d/%0d/%0d expected 0", stateMain, stateNoTrap, stateNoHs);
      end
      checks++;
      if (instretMain !== 32'd0 || instretNoTrap !== 4'd0 || instretNoHs !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset instret: got %0d/%0d/%0d expected 0", instretMain, instretNoTrap, instretNoHs);
      end
      checks++;
      if (ctrlMain !== expectOut(0, op, f3, 1'b0)) begin
         errors++;
         $display("[TB] FAIL reset outputs: got %h expected %h", ctrlMain, expectOut(0, op, f3, 1'b0));
      end
      checks++;
      if (ctrlNoHs !== expectOut(0, op, f3, 1'b0)) begin
         errors++;
         $display("[TB] FAIL reset outputsNoHs: got %h expected %h", ctrlNoHs, expectOut(0, op, f3, 1'b0));
      end
      @(posedge CLK);
      #1;
      RST = 1'b0;
      expCount = 0;
   endtask

   task automatic test_directed();
      doReset();
      runInstruction(OPC_REG, 3'b000, 0, 0);
      runInstruction(OPC_LOAD, 3'b010, 0, 3);
      runInstruction(OPC_STORE, 3'b000, 1, 2);
      runInstruction(OPC_JAL, 3'b000, 0, 0);
      runInstruction(OPC_IMM, 3'b101, 0, 0);
   endtask

   task automatic test_random();
      logic [6:0] legalOps [9] = '{OPC_LOAD, OPC_STORE, OPC_REG, OPC_BR, OPC_JAL,
                                   OPC_JALR, OPC_IMM, OPC_LUI, OPC_AUIPC};
      logic [2:0] loadF3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      logic [6:0] op;
      logic [2:0] f3;
      doReset();
      for (int n = 0; n < 40; n++) begin
         op = legalOps[$urandom_range(0, 8)];
         if (op == OPC_LOAD)
            f3 = loadF3[$urandom_range(0, 4)];
         else if (op == OPC_STORE)
            f3 = 3'($urandom_range(0, 2));
         else
            f3 = 3'($urandom);
         runInstruction(op, f3, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end
   endtask

   task automatic test_illegal();
      logic [6:0] illOp [7] = '{7'b0000000, 7'b1111111, OPC_LOAD, OPC_LOAD, OPC_LOAD, OPC_STORE, OPC_STORE};
      logic [2:0] illF3 [7] = '{3'b000, 3'b101, 3'b011, 3'b110, 3'b111, 3'b100, 3'b111};
      for (int k = 0; k < 7; k++) begin
         doReset();
         runInstruction(OPC_REG, 3'b000, 0, 0);
         applyStimulus(illOp[k], illF3[k], 1'b1);
         @(posedge CLK);
         #1;
         @(negedge CLK);
         checks++;
         if (stateMain !== 4'd1 || stateNoTrap !== 4'd1) begin
            errors++;
            $display("[TB] FAIL illegal decode op=%b f3=%b: got %0d/%0d expected 1", illOp[k], illF3[k], stateMain, stateNoTrap);
         end
         @(posedge CLK);
         #1;
         applyStimulus(illOp[k], illF3[k], 1'b0);
         repeat (2) begin
            @(negedge CLK);
            checks++;
            if (stateMain !== 4'd15 || ctrlMain !== expectOut(15, illOp[k], illF3[k], 1'b0)) begin
               errors++;
               $display("[TB] FAIL illegal trap op=%b f3=%b: got state %0d ctrl %h expected 15 %h", illOp[k], illF3[k], stateMain, ctrlMain, expectOut(15, illOp[k], illF3[k], 1'b0));
            end
            checks++;
            if (stateNoTrap !== 4'd0 || ctrlNoTrap !== expectOut(0, illOp[k], illF3[k], 1'b0)) begin
               errors++;
               $display("[TB] FAIL illegal drop op=%b f3=%b: got state %0d ctrl %h expected 0", illOp[k], illF3[k], stateNoTrap, ctrlNoTrap);
            end
            checks++;
            if (instretNoTrap !== 4'd1 || instretMain !== 32'd1) begin
               errors++;
               $display("[TB] FAIL illegal instret: got %0d/%0d expected 1", instretMain, instretNoTrap);
            end
            @(posedge CLK);
            #1;
         end
      end
   endtask

   task automatic test_trap_hold();
      logic [6:0] op;
      logic [2:0] f3;
      logic rdy;
      doReset();
      applyStimulus(7'b0000000, 3'b000, 1'b1);
      repeat (2) begin
         @(posedge CLK);
         #1;
      end
      for (int c = 0; c < 100; c++) begin
         op = 7'($urandom);
         f3 = 3'($urandom);
         rdy = randBit();
         applyStimulus(op, f3, rdy);
         @(negedge CLK);
         checks++;
         if (stateMain !== 4'd15 || ctrlMain !== expectOut(15, op, f3, rdy)) begin
            errors++;
            $display("[TB] FAIL trap hold cycle %0d: got state %0d ctrl %h expected 15 %h", c, stateMain, ctrlMain, expectOut(15, op, f3, rdy));
         end
         checks++;
         if (instretMain !== 32'd0) begin
            errors++;
            $display("[TB] FAIL trap instret: got %0d expected 0", instretMain);
         end
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_reset_abort();
      doReset();
      runInstruction(OPC_REG, 3'b000, 0, 0);
      runInstruction(OPC_LUI, 3'b000, 0, 0);
      applyStimulus(OPC_STORE, 3'b000, 1'b1);
      @(posedge CLK);
      #1;
      applyStimulus(OPC_STORE, 3'b000, 1'b0);
      repeat (3) begin
         @(posedge CLK);
         #1;
      end
      @(negedge CLK);
      checks++;
      if (stateMain !== 4'd5 || ctrlMain !== expectOut(5, OPC_STORE, 3'b000, 1'b0)) begin
         errors++;
         $display("[TB] FAIL stalled store: got state %0d ctrl %h expected 5 %h", stateMain, ctrlMain, expectOut(5, OPC_STORE, 3'b000, 1'b0));
      end
      RST = 1'b1;
      #1;
      checks++;
      if (stateMain !== 4'd0 || instretMain !== 32'd0 || ctrlMain[17] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort: got state %0d instret %0d mem_write %b expected 0 0 0", stateMain, instretMain, ctrlMain[17]);
      end
      checks++;
      if (stateNoTrap !== 4'd0 || instretNoTrap !== 4'd0 || ctrlNoTrap !== expectOut(0, OPC_STORE, 3'b000, 1'b0)) begin
         errors++;
         $display("[TB] FAIL abortNoTrap: got state %0d instret %0d ctrl %h", stateNoTrap, instretNoTrap, ctrlNoTrap);
      end
      @(posedge CLK);
      #1;
      RST = 1'b0;
      expCount = 0;
      runInstruction(OPC_BR, 3'b001, 0, 0);
      runInstruction(OPC_JALR, 3'b000, 0, 0);
   endtask

   task automatic test_no_handshake();
      int seq [4] = '{0, 1, 6, 7};
      doReset();
      applyStimulus(OPC_REG, 3'b000, 1'b0);
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         checks++;
         if (stateNoHs !== 4'(seq[c % 4]) || ctrlNoHs !== expectOut(seq[c % 4], OPC_REG, 3'b000, 1'b1)) begin
            errors++;
            $display("[TB] FAIL noHs cycle %0d: got state %0d ctrl %h expected %0d %h", c, stateNoHs, ctrlNoHs, seq[c % 4], expectOut(seq[c % 4], OPC_REG, 3'b000, 1'b1));
         end
         checks++;
         if (instretNoHs !== 8'(c / 4) || aluOpNoHs !== OPC_REG) begin
            errors++;
            $display("[TB] FAIL noHs instret: got %0d expected %0d", instretNoHs, c / 4);
         end
         checks++;
         if (stateMain !== 4'd0 || ctrlMain !== expectOut(0, OPC_REG, 3'b000, 1'b0)) begin
            errors++;
            $display("[TB] FAIL fetch stall cycle %0d: got state %0d ctrl %h", c, stateMain, ctrlMain);
         end
         @(posedge CLK);
         #1;
      end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_directed();
      test_random();
      test_illegal();
      test_trap_hold();
      test_reset_abort();
      test_no_handshake();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
